// File: rtl/risc_ctrl_if.sv
// Control bundle between the tiny-RISC sequencer and its datapath/memory.
// The master is the sequencer. The slave is the datapath side, which supplies
// the opcode, zero flag and memory ack, and receives the strobes.
interface risc_ctrl_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       sel_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       inc_pc;
  logic       load_pc;
  logic       load_acc;
  logic       pass;
  logic       add;
  logic       halt;
  logic       mem_err;
  logic [2:0] state;

  modport master (
    input  opcode, zero, mem_ack,
    output sel_addr, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_acc,
           pass, add, halt, mem_err, state
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  sel_addr, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_acc,
           pass, add, halt, mem_err, state
  );
endinterface

// File: rtl/risc_control_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit tiny RISC CPU.
// Optional feature: define MEM_TIMEOUT_EN to halt with mem_err when memory
// fails to ack within TIMEOUT_CYCLES wait cycles. Without the macro the
// sequencer waits forever and mem_err is tied low.
module risc_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  risc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    OPRD   = 3'd3,
    STORE  = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_LDA = 3'b011;
  localparam logic [2:0] OP_STO = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;

  // Reject a timeout that the wait counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..2**CNT_W-1");
  end

  state_t state_q, state_d;
  logic   timeout;
  logic   wait_state;

  assign wait_state = (state_q == FETCH) || (state_q == OPRD) || (state_q == STORE);

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q, err_d;

  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !bus.mem_ack;
`else
  assign timeout = 1'b0;
`endif

  // Output decode and next-state selection from state, opcode, zero and ack.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
`ifdef MEM_TIMEOUT_EN
    err_d        = err_q;
`endif
    bus.sel_addr = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.load_ir  = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.load_pc  = 1'b0;
    bus.load_acc = 1'b0;
    bus.pass     = 1'b0;
    bus.add      = 1'b0;
    bus.halt     = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ack) begin
          bus.load_ir = 1'b1;
          bus.inc_pc  = 1'b1;
          state_d     = DECODE;
        end else if (timeout) begin
          state_d = HALT;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end

      DECODE: begin
        bus.sel_addr = 1'b1;
        case (bus.opcode)
          OP_HLT:         state_d = HALT;
          OP_SKZ: begin
            bus.inc_pc = bus.zero;
            state_d    = FETCH;
          end
          OP_JMP: begin
            bus.load_pc = 1'b1;
            state_d     = FETCH;
          end
          OP_ADD, OP_LDA: state_d = OPRD;
          OP_STO:         state_d = STORE;
          default:        state_d = FETCH;
        endcase
      end

      OPRD: begin
        bus.sel_addr = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.pass     = (bus.opcode == OP_LDA);
        bus.add      = (bus.opcode == OP_ADD);
        if (bus.mem_ack) begin
          bus.load_acc = 1'b1;
          state_d      = FETCH;
        end else if (timeout) begin
          state_d = HALT;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end

      STORE: begin
        bus.sel_addr = 1'b1;
        bus.mem_wr   = 1'b1;
        if (bus.mem_ack) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = HALT;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end

      HALT:    bus.halt = 1'b1;

      default: state_d = IDLE;
    endcase

    // Reset masks every output, even before the state register has cleared.
    if (rst) begin
      bus.sel_addr = 1'b0;
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.load_ir  = 1'b0;
      bus.inc_pc   = 1'b0;
      bus.load_pc  = 1'b0;
      bus.load_acc = 1'b0;
      bus.pass     = 1'b0;
      bus.add      = 1'b0;
      bus.halt     = 1'b0;
    end
  end

  assign bus.state = rst ? 3'd0 : state_q;

`ifdef MEM_TIMEOUT_EN
  assign bus.mem_err = err_q && !rst;
`else
  assign bus.mem_err = 1'b0;
`endif

  // State register plus wait counter and sticky error flag when enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
    if (rst) begin
      state_q    <= IDLE;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
`ifdef MEM_TIMEOUT_EN
      err_q      <= err_d;
      if (state_d != state_q || bus.mem_ack)
        wait_cnt_q <= '0;
      else if (wait_state)
        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
    end
  end

`ifndef MEM_TIMEOUT_EN
  // Wait-state decode only feeds the timeout counter.
  logic unused_ok;
  assign unused_ok = wait_state;
`endif

endmodule

// File: tb/tb_risc_control_fsm.sv
// Directed self-checking bench for risc_control_fsm.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_risc_control_fsm;

  localparam logic [10:0] SEL  = 11'h400;
  localparam logic [10:0] RD   = 11'h200;
  localparam logic [10:0] WR   = 11'h100;
  localparam logic [10:0] LIR  = 11'h080;
  localparam logic [10:0] INC  = 11'h040;
  localparam logic [10:0] LPC  = 11'h020;
  localparam logic [10:0] LACC = 11'h010;
  localparam logic [10:0] PASS = 11'h008;
  localparam logic [10:0] ADD  = 11'h004;
  localparam logic [10:0] HLT  = 11'h002;
  localparam logic [10:0] ERR  = 11'h001;
  localparam logic [10:0] NONE = 11'h000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  risc_ctrl_if bus ();

  risc_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [10:0] obs;
  assign obs = {bus.sel_addr, bus.mem_rd, bus.mem_wr, bus.load_ir, bus.inc_pc,
                bus.load_pc, bus.load_acc, bus.pass, bus.add, bus.halt, bus.mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Check state and outputs for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [10:0] eo);
    @(negedge clk);
    check({tag, "_state"}, {29'd0, bus.state}, {29'd0, es});
    check({tag, "_outs"}, {21'd0, obs}, {21'd0, eo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.mem_ack = 1'b1;
    bus.opcode  = 3'b000;
    bus.zero    = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with ack high: everything low.
    cyc("rst0", 3'd0, NONE);
    cyc("rst1", 3'd0, NONE);
    rst = 1'b0;
    cyc("idle", 3'd0, NONE);

    // LDA with zero-wait memory.
    bus.opcode = 3'b011;
    cyc("lda_fetch", 3'd1, RD | LIR | INC);
    cyc("lda_dec",   3'd2, SEL);
    cyc("lda_oprd",  3'd3, SEL | RD | PASS | LACC);

    // ADD with two wait cycles in OPRD.
    bus.opcode = 3'b010;
    cyc("add_fetch", 3'd1, RD | LIR | INC);
    cyc("add_dec",   3'd2, SEL);
    bus.mem_ack = 1'b0;
    cyc("add_w1",    3'd3, SEL | RD | ADD);
    cyc("add_w2",    3'd3, SEL | RD | ADD);
    bus.mem_ack = 1'b1;
    cyc("add_ack",   3'd3, SEL | RD | ADD | LACC);

    // SKZ taken, SKZ not taken, JMP, NOP.
    bus.opcode = 3'b001;
    bus.zero   = 1'b1;
    cyc("skz1_fetch", 3'd1, RD | LIR | INC);
    cyc("skz1_dec",   3'd2, SEL | INC);
    bus.zero   = 1'b0;
    cyc("skz0_fetch", 3'd1, RD | LIR | INC);
    cyc("skz0_dec",   3'd2, SEL);
    bus.opcode = 3'b101;
    cyc("jmp_fetch",  3'd1, RD | LIR | INC);
    cyc("jmp_dec",    3'd2, SEL | LPC);
    bus.opcode = 3'b110;
    cyc("nop_fetch",  3'd1, RD | LIR | INC);
    cyc("nop_dec",    3'd2, SEL);

    // STO with two wait cycles.
    bus.opcode = 3'b100;
    cyc("sto_fetch", 3'd1, RD | LIR | INC);
    cyc("sto_dec",   3'd2, SEL);
    bus.mem_ack = 1'b0;
    cyc("sto_w1",    3'd4, SEL | WR);
    cyc("sto_w2",    3'd4, SEL | WR);
    bus.mem_ack = 1'b1;
    cyc("sto_ack",   3'd4, SEL | WR);

    // Reset during an OPRD wait: no load_acc, back to IDLE.
    bus.opcode = 3'b011;
    cyc("rlda_fetch", 3'd1, RD | LIR | INC);
    cyc("rlda_dec",   3'd2, SEL);
    bus.mem_ack = 1'b0;
    cyc("rlda_wait",  3'd3, SEL | RD | PASS);
    rst = 1'b1;
    cyc("rlda_rst",   3'd0, NONE);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    cyc("rlda_idle",  3'd0, NONE);

    // HLT: halt stays up with ack toggling.
    bus.opcode = 3'b000;
    cyc("hlt_fetch", 3'd1, RD | LIR | INC);
    cyc("hlt_dec",   3'd2, SEL);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ack = i[0];
      cyc("halt", 3'd5, HLT);
    end
    rst = 1'b1;
    cyc("hlt_rst", 3'd0, NONE);
    rst = 1'b0;
    cyc("hlt_idle", 3'd0, NONE);

    // Memory never acks in FETCH.
    bus.mem_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc("to_wait", 3'd1, RD);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = i[0];
      cyc("to_halt", 3'd5, HLT | ERR);
    end
    rst = 1'b1;
    cyc("to_rst", 3'd0, NONE);
    rst = 1'b0;
    cyc("to_idle", 3'd0, NONE);
`else
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    cyc("nowait_fetch", 3'd1, RD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
